// File: rtl/div_seq.sv
// Iterative RV32M divider: DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Ports: clk, rst_n, start/op/dividend/divisor in; flush abort; busy, done, result out.
module div_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            rem_op_q, rem_op_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            busy_q, done_q;

    logic            sgn_op, sa, sb, ovf, carry;
    logic [XLEN-1:0] abs_a, abs_b, q_fix, r_fix;
    logic [XLEN:0]   shifted, trial;
    logic            unused_trial_msb;

    assign sgn_op = ~op[0];
    assign sa     = sgn_op & dividend[XLEN-1];
    assign sb     = sgn_op & divisor[XLEN-1];
    assign abs_a  = sa ? -dividend : dividend;
    assign abs_b  = sb ? -divisor : divisor;
    assign ovf    = sgn_op
                  & (dividend == {1'b1, {(XLEN-1){1'b0}}})
                  & (&divisor);

    // Adder-style subtract: carry-out 1 means no borrow.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign {carry, trial} = {1'b0, shifted}
                          + {1'b0, ~{1'b0, dvs_q}}
                          + (XLEN+2)'(1);
    // A successful trial is always below the divisor, so its top bit is 0.
    assign unused_trial_msb = trial[XLEN];

    assign q_fix = negq_q ? -quo_q : quo_q;
    assign r_fix = negr_q ? -rem_q : rem_q;

    always_comb begin
        state_d  = state_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        res_d    = res_q;
        rem_op_d = rem_op_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    rem_op_d = op[1];
                    negq_d   = sa ^ sb;
                    negr_d   = sa;
                    dvs_d    = abs_b;
                    quo_d    = abs_a;
                    rem_d    = '0;
                    cnt_d    = '0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        res_d   = op[1] ? dividend : '1;
                    end else if (ovf) begin
                        state_d = DONE;
                        res_d   = op[1] ? '0 : dividend;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = carry ? trial[XLEN-1:0] : shifted[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], carry};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(XLEN-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                res_d   = rem_op_q ? r_fix : q_fix;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush) begin
            state_d = IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            res_q    <= '0;
            rem_op_q <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            res_q    <= res_d;
            rem_op_q <= rem_op_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            cnt_q    <= cnt_d;
            busy_q   <= (state_d == CALC) || (state_d == FIX);
            done_q   <= (state_d == DONE);
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = res_q;

endmodule

// File: tb/tb_div_seq.sv
// Randomised bench for div_seq against a cycle-timestamp reference model.
// Checks busy/done/result every cycle plus directed literal cases.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit          has_op = 0;
    bit          aborted = 0;
    bit          special = 0;
    int          acc_t = 0;
    int          abort_t = 0;
    int          end_t = 0;
    logic [31:0] exp_val = '0;
    logic [31:0] held = '0;

    div_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .dividend(dividend), .divisor(divisor), .flush(flush),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        if (b == 0) return o[1] ? a : 32'hFFFFFFFF;
        if (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)
            return o[1] ? 32'h0 : a;
        case (o)
            2'd0:    return $signed(a) / $signed(b);
            2'd1:    return a / b;
            2'd2:    return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] o,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 0) || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
    endfunction

    function bit idle_at(input int n);
        if (!has_op) return 1;
        return aborted ? (n > abort_t) : (n > end_t);
    endfunction

    function bit act_at(input int n);
        return has_op && !(aborted && n > abort_t);
    endfunction

    // Model: end of cycle cyc, decide acceptance/abort from the rules.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            has_op  = 0;
            aborted = 0;
            held    = '0;
        end else begin
            if (act_at(cyc) && cyc == end_t) held = exp_val;
            if (flush) begin
                if (has_op && !idle_at(cyc)) begin
                    aborted = 1;
                    abort_t = cyc;
                end
            end else if (start && idle_at(cyc)) begin
                has_op  = 1;
                aborted = 0;
                acc_t   = cyc;
                special = is_special(op, dividend, divisor);
                exp_val = ref_div(op, dividend, divisor);
                end_t   = cyc + (special ? 1 : 34);
            end
        end
    end

    initial forever begin
        bit eb, ed;
        @(negedge clk);
        if (!rst_n) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_result", result, 0);
        end else begin
            eb = act_at(cyc) && !special && cyc >= acc_t + 1 && cyc <= acc_t + 33;
            ed = act_at(cyc) && cyc == end_t;
            check("busy", busy, eb);
            check("done", done, ed);
            check("result", result, ed ? exp_val : held);
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int lat, input bit junk, input bit now);
        int c, d;
        bit seen;
        if (!now) @(negedge clk);
        op = o; dividend = a; divisor = b; start = 1; flush = 0;
        c = cyc;
        d = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                d = cyc;
            end
            start    = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            op       = 2'($urandom);
            dividend = $urandom;
            divisor  = $urandom;
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
        end else begin
            check("op_result", result, exp);
            check("op_latency", d - c, lat);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return $urandom;
            1:       return $urandom_range(0, 20);
            2:       return 32'(0 - $urandom_range(1, 20));
            3:       return 32'h80000000;
            4:       return 32'hFFFFFFFF;
            default: return $urandom_range(0, 1);
        endcase
    endfunction

    initial begin
        int c;
        logic [1:0] o;
        logic [31:0] a, b;
        check("model_divu", ref_div(2'd1, 100, 7), 14);
        check("model_remu", ref_div(2'd3, 100, 7), 2);
        check("model_div_neg", ref_div(2'd0, 32'hFFFFFFF9, 2), 32'hFFFFFFFD);
        check("model_rem_neg", ref_div(2'd2, 32'hFFFFFFF9, 2), 32'hFFFFFFFF);
        check("model_rem_dvs", ref_div(2'd2, 7, 32'hFFFFFFFE), 1);
        check("model_div0", ref_div(2'd0, 32'h12345678, 0), 32'hFFFFFFFF);
        check("model_ovf_rem", ref_div(2'd2, 32'h80000000, 32'hFFFFFFFF), 0);

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op(2'd1, 100, 7, 14, 34, 0, 0);
        run_op(2'd3, 100, 7, 2, 34, 1, 0);
        run_op(2'd0, 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 34, 0, 0);
        run_op(2'd2, 32'hFFFFFFF9, 2, 32'hFFFFFFFF, 34, 1, 0);
        run_op(2'd0, 32'h12345678, 0, 32'hFFFFFFFF, 1, 0, 0);
        run_op(2'd1, 32'h12345678, 0, 32'hFFFFFFFF, 1, 0, 0);
        run_op(2'd2, 32'h12345678, 0, 32'h12345678, 1, 0, 0);
        run_op(2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, 0);
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 1, 0, 0);
        run_op(2'd1, 32'h80000000, 32'hFFFFFFFF, 0, 34, 1, 0);
        run_op(2'd2, 7, 32'hFFFFFFFE, 1, 34, 0, 0);

        @(negedge clk);
        op = 2'd1; dividend = 1000; divisor = 3; start = 1; flush = 0;
        c = cyc;
        @(negedge clk);
        start = 0;
        while (cyc < c + 10) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        check("flush_busy", busy, 0);
        check("flush_hold", result, 1);
        run_op(2'd1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 34, 0, 1);

        @(negedge clk);
        op = 2'd0; dividend = 32'h7654321; divisor = 5; start = 1;
        c = cyc;
        @(negedge clk);
        start = 0;
        while (cyc < c + 20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_result", result, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            run_op(o, a, b, ref_div(o, a, b),
                   is_special(o, a, b) ? 1 : 34,
                   1'($urandom_range(0, 1)), 0);
        end

        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative RV32M divide unit for the single-cycle core; executes DIV, DIVU, REM and REMU over multiple cycles while the core stalls on `busy`. It sits beside the ALU adder and uses the same subtract convention: rem + ~divisor + 1 with carry-in 1, where carry-out 1 means no borrow. Its result feeds the writeback mux like any ALU result.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width. Only 32 is supported.

Ports:
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request a division. Sampled only in IDLE.
- `op`  in  2: operation select. 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `dividend`  in  32: rs1 value. Sampled with `start`.
- `divisor`  in  32: rs2 value. Sampled with `start`.
- `flush`  in  1: abort any operation in progress.
- `busy`  out  1: high while the operation is in progress. The core stalls while it is high.
- `done`  out  1: one-cycle pulse; `result` is valid in that cycle.
- `result`  out  32: quotient or remainder. Holds its value until the next `done`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Reset (asynchronous): state IDLE, `busy`=0, `done`=0, `result`=0, internal registers 0.
- IDLE + `start`=1 latches `op`, operands, sign flags and absolute values (signed ops only).
  - divisor == 0: go to DONE. Result is 0xFFFFFFFF for DIV/DIVU and `dividend` for REM/REMU.
  - DIV with dividend 0x80000000 and divisor 0xFFFFFFFF: go to DONE. Result is 0x80000000 for DIV and 0 for REM.
  - Otherwise: go to CALC, set the iteration count to 0 and load quotient = |dividend|, remainder = 0.
- CALC: restoring algorithm, one bit per cycle.
  - Shift {rem, quo} left by 1, then trial = rem_shifted + ~|divisor| + 1 (33-bit).
  - carry=1: rem = trial, quotient LSB = 1. carry=0: rem unchanged, quotient LSB = 0.
  - After 32 iterations go to FIX.
- FIX (signed ops only):
  - Negate the quotient when the dividend and divisor signs differ.
  - Give the remainder the sign of the dividend.
  - Write `result`, then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE. A `start` in DONE is ignored.
- `flush`=1 in any state: next state IDLE, `busy`=0, no `done`, `result` unchanged. `flush` has priority over `start`.
- `start` while not in IDLE: ignored. Operand changes after acceptance do not affect the result.
- Operation width: all arithmetic is 33-bit internally. Negation is two's complement. |0x80000000| = 0x80000000, treated as unsigned.

## Timing
- `busy` is registered and equals (state is CALC or FIX).
- `done` is registered and equals (state is DONE).
- Normal op, with `start` in cycle 0:
  - `busy` is high in cycles 1–33 (CALC cycles 1–32, FIX cycle 33).
  - `done` and `result` are valid in cycle 34.
  - A new `start` is accepted in cycle 35 (IDLE).
- Divide-by-zero or overflow: `done` in cycle 1 and `busy` never rises. A new `start` is accepted in cycle 2.
- Back-to-back ops are allowed with no gap other than the DONE cycle.
- Reset asserted mid-operation: outputs clear immediately and asynchronously; no `done`.
- `flush` in cycle k while busy: `busy`=0 in cycle k+1.

## Test plan
- DIVU 100 / 7, `start` in cycle 0 → `busy` in cycles 1–33, `done` in cycle 34 with `result`=14. REMU with the same operands → 2.
- DIV −7 / 2 → 0xFFFFFFFD (−3). REM −7 / 2 → 0xFFFFFFFF (−1). REM 7 / −2 → 1.
- DIV and DIVU with divisor 0, dividend 0x12345678 → `done` in cycle 1, `result`=0xFFFFFFFF. REM → 0x12345678.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 in cycle 1; REM → 0. DIVU with the same operands → 0 after 34 cycles.
- `flush` in cycle 10 of an op → `busy`=0 in cycle 11, no `done`, `result` keeps its previous value. An immediately following DIVU 0xFFFFFFFF / 1 → 0xFFFFFFFF.
- `rst_n` low in cycle 20 of an op → `busy`, `done` and `result` are 0 asynchronously. `start` pulses while busy are ignored. Random signed and unsigned operands checked against a reference model.
